// File: rtl/fadd_reduce_if.sv
// Bundles the element stream, the external adder hookup and the result handshake.
// The master modport is the surrounding logic, the slave modport is fadd_reduce.
interface fadd_reduce_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_op;
    logic [31:0] add_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid, in_data, in_last, add_out, out_ready,
        input  in_ready, add_a, add_b, add_op, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_last, add_out, out_ready,
        output in_ready, add_a, add_b, add_op, out_valid, out_data
    );
endinterface

// File: rtl/fadd_reduce.sv
// Float stream sum over a 4-deep external adder: 4 interleaved lanes, then a tree of the partials.
// Result 15 cycles after the last accept; input stalls from last accept until the result is taken.
module fadd_reduce (
    input  logic         clk,
    input  logic         rst,
    fadd_reduce_if.slave io
);
    typedef enum logic [1:0] {ACCUM, COLLECT, REDUCE, OUT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_slot;
    logic [3:0]  r_live;
    logic [3:0]  r_cnt;
    logic [31:0] r_p [4];
    logic [31:0] r_r0;
    logic [31:0] r_out_data;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_live_out;
    logic        w_issue_live;
    logic [31:0] w_add_a;
    logic [31:0] w_add_b;
    logic [31:0] w_masked_out;
    logic        w_out_hs;

    assign w_in_ready   = (r_state == ACCUM) && !rst;
    assign w_accept     = io.in_valid && w_in_ready;
    // Slot index repeats every 4 cycles, matching the adder depth, so this bit was written 4 cycles ago.
    assign w_live_out   = r_live[r_slot];
    assign w_masked_out = w_live_out ? io.add_out : 32'h0000_0000;
    assign w_out_hs     = (r_state == OUT) && io.out_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_add_a      = 32'h0000_0000;
        w_add_b      = 32'h0000_0000;
        w_issue_live = 1'b0;
        case (r_state)
            ACCUM: begin
                w_add_a      = w_accept ? io.in_data : 32'h0000_0000;
                w_add_b      = w_masked_out;
                w_issue_live = 1'b1;
                if (w_accept && io.in_last) begin
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (r_cnt == 4'd3) begin
                    w_state_nxt = REDUCE;
                end
            end
            REDUCE: begin
                case (r_cnt)
                    4'd4: begin
                        w_add_a = r_p[0];
                        w_add_b = r_p[1];
                    end
                    4'd5: begin
                        w_add_a = r_p[2];
                        w_add_b = r_p[3];
                    end
                    4'd9: begin
                        w_add_a = r_r0;
                        w_add_b = io.add_out;
                    end
                    default: begin
                    end
                endcase
                if (r_cnt == 4'd13) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                if (w_out_hs) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ACCUM;
            r_slot     <= 2'd0;
            r_live     <= 4'd0;
            r_cnt      <= 4'd0;
            r_r0       <= 32'h0000_0000;
            r_out_data <= 32'h0000_0000;
            for (int k = 0; k < 4; k++) begin
                r_p[k] <= 32'h0000_0000;
            end
        end else begin
            r_state        <= w_state_nxt;
            r_slot         <= r_slot + 2'd1;
            r_live[r_slot] <= w_issue_live;
            r_cnt          <= (r_state == ACCUM) ? 4'd0 : r_cnt + 4'd1;
            if (r_state == COLLECT) begin
                r_p[r_cnt[1:0]] <= w_masked_out;
            end
            if ((r_state == REDUCE) && (r_cnt == 4'd8)) begin
                r_r0 <= io.add_out;
            end
            if ((r_state == REDUCE) && (r_cnt == 4'd13)) begin
                r_out_data <= io.add_out;
            end
        end
    end

    assign io.in_ready  = w_in_ready;
    assign io.add_a     = w_add_a;
    assign io.add_b     = w_add_b;
    assign io.add_op    = 1'b0;
    assign io.out_valid = (r_state == OUT);
    assign io.out_data  = r_out_data;
endmodule

// File: doc/fadd_reduce.md
FADD_REDUCE -- requirements
Module: fadd_reduce

Interface
REQ-001 Parameters: none; the attached adder latency SHALL be fixed at 4 cycles from operand issue to registered result.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  stream element present.
REQ-005 in_ready  output  1  block accepts element this cycle.
REQ-006 in_data  input  32  IEEE-754 single element.
REQ-007 in_last  input  1  marks final element of a stream.
REQ-008 add_a  output  32  adder operand 1 (drives adder in1).
REQ-009 add_b  output  32  adder operand 2 (drives adder in2).
REQ-010 add_op  output  1  adder op; SHALL be constant 0 (plus).
REQ-011 add_out  input  32  adder registered result.
REQ-012 out_valid  output  1  reduced sum present.
REQ-013 out_ready  input  1  consumer accepts sum.
REQ-014 out_data  output  32  reduced sum of the stream.

Function
REQ-015 Accept = in_valid & in_ready; result handshake = out_valid & out_ready.
REQ-016 States: ACCUM, COLLECT, REDUCE, OUT; in_ready SHALL be 1 only in ACCUM (and 0 while rst high).
REQ-017 A 2-bit slot counter SHALL increment every cycle in all states; results in add_out at cycle t belong to the slot issued at t-4 (same slot index).
REQ-018 A 4-bit live delay line SHALL record, per issue cycle, whether that issue was an ACCUM circulation; live-out = bit issued 4 cycles earlier.
REQ-019 ACCUM, every cycle: add_a = accepted ? in_data : 32'h00000000; add_b = live-out ? add_out : 32'h00000000; issue marked live.
REQ-020 Accept with in_last=1 in cycle t: element SHALL be added as in REQ-019; state -> COLLECT for cycles t+1..t+4.
REQ-021 COLLECT: capture (live-out ? add_out : 0) into partial register p[k], k = 0..3 for cycles t+1..t+4; issue zeros, not live.
REQ-022 REDUCE (internal cycle counter): issue (p0,p1) at t+5 and (p2,p3) at t+6; capture add_out as r0 at t+9; at t+10 issue (r0, add_out); capture add_out into out_data at end of t+14; all other REDUCE issues zeros, not live.
REQ-023 out_valid SHALL rise in cycle t+15 (fixed latency 15 cycles from last accept) and state -> OUT.
REQ-024 OUT: out_valid and out_data SHALL hold stable until handshake; on handshake out_valid falls next cycle, state -> ACCUM, in_ready=1 next cycle.
REQ-025 Partials SHALL restart from zero for each stream (non-live issues during COLLECT/REDUCE/OUT guarantee this); no regs are cleared explicitly between streams.
REQ-026 Single-element stream (first accept has in_last) SHALL follow identical timing.
REQ-027 in_valid while in_ready=0 SHALL be ignored; no element lost or duplicated.
REQ-028 Summation order is lane-interleaved (element i to slot (cycle mod 4)); results SHALL match that order bit-exactly with adder rounding, not sequential order.

Reset
REQ-029 rst high SHALL asynchronously force: state ACCUM, out_valid=0, out_data=0, live line=0, counters=0, p/r registers=0, in_ready=0.
REQ-030 After rst falls, in_ready=1 next cycle; adder contents from before reset SHALL never contribute (masked by live line).
REQ-031 Reset mid-COLLECT/REDUCE/OUT SHALL abort the stream with no out_valid pulse for it.

Verification
REQ-032 Reset: rst pulse, no input -> out_valid=0, in_ready=0 during reset, 1 the cycle after release.
REQ-033 Single 32'h3F800000 (1.0) with in_last at cycle t -> out_valid at t+15, out_data 32'h3F800000.
REQ-034 1.0..8.0 back-to-back, in_last on 8.0 -> out_data 32'h42100000 (36.0).
REQ-035 2.0, three idle cycles, 3.0 with in_last -> out_data 32'h40A00000 (5.0).
REQ-036 out_ready low 5 cycles at result -> out_valid/out_data stable, in_ready=0; after handshake, stream 4.0-last -> 32'h40800000.
REQ-037 rst asserted at t+8 of a stream -> no out_valid for it; following stream 4.0-last -> out_data 32'h40800000 at its t+15.
